// File: rtl/hazard_forward_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types, forward-select encodings and the match helper
//             used by the hazard/forwarding control block.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Storage width for register numbers inside the shadow pipeline.
    // Register numbers are zero-extended into it, so REG_ADDR_W must not exceed it.
    localparam int C_DST_W = 8;

    // EX operand mux select encodings (2'b11 is never driven).
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef logic [C_DST_W-1:0] dst_t;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic valid;
        dst_t dst;
        logic reg_write;
        logic mem_read;
    } shadow_entry_t;

    // Producer-consumer match; register 0 is hard-wired and never matches.
    function automatic logic entry_match(input shadow_entry_t e,
                                         input dst_t          r,
                                         input logic          used);
        return e.valid & e.reg_write & (e.dst == r) & (r != '0) & used;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_forward_ctrl_mdu_busy_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_busy_counter
//  Purpose  : Load/decrement occupancy counter for the multiply/divide unit.
//             mdu_busy is high while the counter is non-zero.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_busy_counter #(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic mdu_busy
);

    // MDU_LAT is limited to 1..15, so four bits always suffice.
    localparam int                 C_CNT_W    = 4;
    localparam logic [C_CNT_W-1:0] C_LOAD_VAL = C_CNT_W'(MDU_LAT);
    localparam logic [C_CNT_W-1:0] C_ONE      = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_count;

    // Reload on MDU issue, otherwise count down to zero and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= C_LOAD_VAL;
        end else if (r_count != '0) begin
            r_count <= r_count - C_ONE;
        end
    end

    assign mdu_busy = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_forward_ctrl
//  Purpose  : ID-stage hazard unit. Tracks in-flight destinations in a shadow
//             EX/MEM/WB pipeline, drives registered EX operand forward
//             selects and raises a combinational stall for load-use and
//             MDU-occupancy hazards.
//  Options  : FWD_PATH_EN - when defined, EX/MEM and MEM/WB forwarding is
//             used; when undefined, selects stay at the register file and any
//             dependence on EX or MEM stalls until the producer reaches WB.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MDU_LAT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mdu_op,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  mdu_busy
);

    shadow_entry_t r_ex;
    shadow_entry_t r_mem;
    shadow_entry_t r_wb;
    logic [1:0]    r_fwd_a_sel;
    logic [1:0]    r_fwd_b_sel;

    dst_t          w_rs;
    dst_t          w_rt;
    shadow_entry_t w_id_entry;
    logic          w_ex_a;
    logic          w_ex_b;
    logic          w_mem_a;
    logic          w_mem_b;
    logic          w_data_hazard;
    logic          w_issue;
    logic [1:0]    w_sel_a;
    logic [1:0]    w_sel_b;

    assign w_rs = dst_t'(id_rs);
    assign w_rt = dst_t'(id_rt);

    assign w_id_entry.valid     = 1'b1;
    assign w_id_entry.dst       = dst_t'(id_dst);
    assign w_id_entry.reg_write = id_reg_write;
    assign w_id_entry.mem_read  = id_mem_read;

    assign w_ex_a  = entry_match(r_ex,  w_rs, id_use_rs);
    assign w_ex_b  = entry_match(r_ex,  w_rt, id_use_rt);
    assign w_mem_a = entry_match(r_mem, w_rs, id_use_rs);
    assign w_mem_b = entry_match(r_mem, w_rt, id_use_rt);

`ifdef FWD_PATH_EN
    // Only a load in EX cannot be forwarded; the youngest producer wins.
    assign w_data_hazard = (w_ex_a | w_ex_b) & r_ex.mem_read;
    assign w_sel_a = (w_ex_a & ~r_ex.mem_read) ? FWD_EXMEM :
                     w_mem_a                   ? FWD_MEMWB : FWD_RF;
    assign w_sel_b = (w_ex_b & ~r_ex.mem_read) ? FWD_EXMEM :
                     w_mem_b                   ? FWD_MEMWB : FWD_RF;
`else
    // No bypass paths: wait until every producer has left MEM.
    assign w_data_hazard = w_ex_a | w_ex_b | w_mem_a | w_mem_b;
    assign w_sel_a       = FWD_RF;
    assign w_sel_b       = FWD_RF;
`endif

    assign stall   = id_valid & ~flush & (w_data_hazard | (id_mdu_op & mdu_busy));
    assign w_issue = id_valid & ~stall & ~flush;

    // Advance the shadow pipeline; stalls and flushes insert a bubble in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_fwd_a_sel <= FWD_RF;
            r_fwd_b_sel <= FWD_RF;
        end else begin
            r_wb        <= r_mem;
            r_mem       <= r_ex;
            r_ex        <= w_issue ? w_id_entry : '0;
            r_fwd_a_sel <= w_issue ? w_sel_a : FWD_RF;
            r_fwd_b_sel <= w_issue ? w_sel_b : FWD_RF;
        end
    end

    assign fwd_a_sel = r_fwd_a_sel;
    assign fwd_b_sel = r_fwd_b_sel;

    mdu_busy_counter #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_busy_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_issue & id_mdu_op),
        .mdu_busy (mdu_busy)
    );

    // WB is tracked for completeness only (the register file is
    // write-through), and load flags beyond EX are never consulted.
    logic w_unused_bits;
    assign w_unused_bits = ^{r_wb, r_mem.mem_read, r_ex.mem_read};

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_forward_ctrl
//  Purpose  : Directed, table-driven bench for hazard_forward_ctrl with
//             hand-computed expectations for both FWD_PATH_EN settings.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int K_IDLE = 0;
    localparam int K_ALU  = 1;
    localparam int K_LW   = 2;
    localparam int K_MULT = 3;
    localparam int K_MFLO = 4;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       use_rs;
        logic       use_rt;
        logic       rw;
        logic       mr;
        logic       mdu;
        logic       flush;
        logic       exp_stall;
        logic       exp_busy;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_dst;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_mdu_op;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       mdu_busy;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    hazard_forward_ctrl #(
        .REG_ADDR_W (5),
        .MDU_LAT    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mdu_op    (id_mdu_op),
        .flush        (flush),
        .stall        (stall),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .mdu_busy     (mdu_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    // Build one cycle of ID-stage activity with its expected outputs.
    task automatic push(input int k, input int d, input int s, input int t,
                        input logic fl, input logic st, input logic bz,
                        input logic [1:0] a, input logic [1:0] b);
        vec_t v;
        v.valid  = (k != K_IDLE);
        v.dst    = 5'(d);
        v.rs     = 5'(s);
        v.rt     = 5'(t);
        v.use_rs = (k == K_ALU) || (k == K_LW) || (k == K_MULT);
        v.use_rt = (k == K_ALU) || (k == K_MULT);
        v.rw     = (k == K_ALU) || (k == K_LW) || (k == K_MFLO);
        v.mr     = (k == K_LW);
        v.mdu    = (k == K_MULT) || (k == K_MFLO);
        v.flush  = fl;
        v.exp_stall = st;
        v.exp_busy  = bz;
        v.exp_a     = a;
        v.exp_b     = b;
        vecs.push_back(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(K_IDLE, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    endtask

    task automatic drive(input vec_t v);
        id_valid     = v.valid;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_dst       = v.dst;
        id_use_rs    = v.use_rs;
        id_use_rt    = v.use_rt;
        id_reg_write = v.rw;
        id_mem_read  = v.mr;
        id_mdu_op    = v.mdu;
        flush        = v.flush;
    endtask

    task automatic drive_ins(input int k, input int d, input int s, input int t);
        vecs.delete();
        push(k, d, s, t, 0, 0, 0, 2'b00, 2'b00);
        drive(vecs[0]);
    endtask

    initial begin
        // ---------------- vector table ----------------
        idle(2);
`ifdef FWD_PATH_EN
        // add $3 ; add $4,$3,$5 -> EX/MEM forward on A, no stall
        push(K_ALU, 3, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 4, 3, 5, 0, 0, 0, 2'b10, 2'b00);
        idle(3);
        // add $3 ; nop ; sub $6,$7,$3 -> MEM/WB forward on B
        push(K_ALU, 3, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        idle(1);
        push(K_ALU, 6, 7, 3, 0, 0, 0, 2'b00, 2'b01);
        idle(3);
        // lw $8 ; add $9,$8,$8 -> one stall, bubble, then MEM/WB on both
        push(K_LW,  8, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 9, 8, 8, 0, 1, 0, 2'b00, 2'b00);
        push(K_ALU, 9, 8, 8, 0, 0, 0, 2'b01, 2'b01);
        idle(3);
        // add $3 ; add $3 ; add $5,$3,$3 -> youngest producer (EX) wins
        push(K_ALU, 3, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 3, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 5, 3, 3, 0, 0, 0, 2'b10, 2'b10);
        idle(3);
        // lw $8 ; nop ; add $9,$2,$8 -> no stall, MEM/WB on B
        push(K_LW,  8, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        idle(1);
        push(K_ALU, 9, 2, 8, 0, 0, 0, 2'b00, 2'b01);
        idle(3);
`else
        // add $3 ; add $4,$3,$5 -> two stalls, register file only
        push(K_ALU, 3, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 4, 3, 5, 0, 1, 0, 2'b00, 2'b00);
        push(K_ALU, 4, 3, 5, 0, 1, 0, 2'b00, 2'b00);
        push(K_ALU, 4, 3, 5, 0, 0, 0, 2'b00, 2'b00);
        idle(3);
        // add $3 ; nop ; sub $6,$7,$3 -> one stall
        push(K_ALU, 3, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        idle(1);
        push(K_ALU, 6, 7, 3, 0, 1, 0, 2'b00, 2'b00);
        push(K_ALU, 6, 7, 3, 0, 0, 0, 2'b00, 2'b00);
        idle(3);
        // lw $8 ; add $9,$8,$8 -> two stalls
        push(K_LW,  8, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 9, 8, 8, 0, 1, 0, 2'b00, 2'b00);
        push(K_ALU, 9, 8, 8, 0, 1, 0, 2'b00, 2'b00);
        push(K_ALU, 9, 8, 8, 0, 0, 0, 2'b00, 2'b00);
        idle(3);
        // add $3 ; add $3 ; add $5,$3,$3 -> stall until both producers pass MEM
        push(K_ALU, 3, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 3, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 5, 3, 3, 0, 1, 0, 2'b00, 2'b00);
        push(K_ALU, 5, 3, 3, 0, 1, 0, 2'b00, 2'b00);
        push(K_ALU, 5, 3, 3, 0, 0, 0, 2'b00, 2'b00);
        idle(3);
        // lw $8 ; nop ; add $9,$2,$8 -> one stall
        push(K_LW,  8, 1, 0, 0, 0, 0, 2'b00, 2'b00);
        idle(1);
        push(K_ALU, 9, 2, 8, 0, 1, 0, 2'b00, 2'b00);
        push(K_ALU, 9, 2, 8, 0, 0, 0, 2'b00, 2'b00);
        idle(3);
`endif
        // addi $0 ; add $1,$0,$0 -> register 0 never matches
        push(K_ALU, 0, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        idle(3);
        // mult ; add ; mflo -> mflo stalls 3 cycles, busy 4 cycles after issue
        push(K_MULT, 0, 1, 2, 0, 0, 0, 2'b00, 2'b00);
        push(K_ALU, 10, 11, 12, 0, 0, 1, 2'b00, 2'b00);
        push(K_MFLO, 13, 0, 0, 0, 1, 1, 2'b00, 2'b00);
        push(K_MFLO, 13, 0, 0, 0, 1, 1, 2'b00, 2'b00);
        push(K_MFLO, 13, 0, 0, 0, 1, 1, 2'b00, 2'b00);
        push(K_MFLO, 13, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        // mult behind mflo stalls; flush drops stall, counter keeps running
        push(K_MULT, 0, 1, 2, 0, 1, 1, 2'b00, 2'b00);
        push(K_MULT, 0, 1, 2, 0, 1, 1, 2'b00, 2'b00);
        push(K_MULT, 0, 1, 2, 1, 0, 1, 2'b00, 2'b00);
        push(K_IDLE, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00);
        idle(2);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive(vecs[0]);
        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd3; id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_mdu_op = 1'b1;
        #12;
        chk("reset_stall", 0, {1'b0, stall}, 2'b00);
        chk("reset_busy",  0, {1'b0, mdu_busy}, 2'b00);
        chk("reset_fwd_a", 0, fwd_a_sel, 2'b00);
        chk("reset_fwd_b", 0, fwd_b_sel, 2'b00);
        drive(vecs[1]);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- table replay ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk("stall",    i, {1'b0, stall},    {1'b0, vecs[i].exp_stall});
            chk("mdu_busy", i, {1'b0, mdu_busy}, {1'b0, vecs[i].exp_busy});
            @(posedge clk); #1;
            chk("fwd_a_sel", i, fwd_a_sel, vecs[i].exp_a);
            chk("fwd_b_sel", i, fwd_b_sel, vecs[i].exp_b);
        end

        // ---------------- reset during an MDU stall ----------------
        drive_ins(K_MULT, 0, 1, 2);
        @(negedge clk);
        chk("seq_mdu_first_stall", 100, {1'b0, stall}, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("seq_mdu_stall", 101, {1'b0, stall}, 2'b01);
        chk("seq_mdu_busy",  101, {1'b0, mdu_busy}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("seq_mdu_rst_stall", 102, {1'b0, stall}, 2'b00);
        chk("seq_mdu_rst_busy",  102, {1'b0, mdu_busy}, 2'b00);
        #1 rst_n = 1'b1;
        chk("seq_mdu_post_stall", 103, {1'b0, stall}, 2'b00);
        @(posedge clk); #1;
        drive_ins(K_IDLE, 0, 0, 0);
        @(negedge clk);
        chk("seq_mdu_reissue_busy", 104, {1'b0, mdu_busy}, 2'b01);
        repeat (6) @(posedge clk);
        #1;

        // ---------------- reset during a data-dependence stall ----------------
        drive_ins(K_ALU, 3, 1, 2);
        @(posedge clk); #1;
        drive_ins(K_ALU, 4, 3, 3);
        @(negedge clk);
`ifdef FWD_PATH_EN
        chk("seq_dep_stall", 110, {1'b0, stall}, 2'b00);
`else
        chk("seq_dep_stall", 110, {1'b0, stall}, 2'b01);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("seq_dep_rst_stall", 111, {1'b0, stall}, 2'b00);
        chk("seq_dep_rst_busy",  111, {1'b0, mdu_busy}, 2'b00);
        #1 rst_n = 1'b1;
        chk("seq_dep_post_stall", 112, {1'b0, stall}, 2'b00);
        @(posedge clk); #1;
        // entries were cleared, so the dependent issues from the register file
        chk("seq_dep_post_fwd_a", 113, fwd_a_sel, 2'b00);
        chk("seq_dep_post_fwd_b", 113, fwd_b_sel, 2'b00);
        drive_ins(K_IDLE, 0, 0, 0);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
